// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: IM fetch port, DM data port and the shared
// single-port SRAM command/return signals.
// slave  = arbiter side, master = requesters plus the SRAM macro.
interface mem_arbiter_if #(
  parameter int ADDR_W = 14
);
  // Instruction-fetch port (read only)
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic              im_grant;
  logic              im_rvalid;
  logic [31:0]       im_rdata;

  // Data port (read/write, per-bit write enable)
  logic              dm_req;
  logic              dm_web;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_bweb;
  logic [31:0]       dm_wdata;
  logic              dm_grant;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;

  // Shared SRAM: read data appears on mem_do one cycle after the command
  logic              mem_ceb;
  logic              mem_web;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_bweb;
  logic [31:0]       mem_di;
  logic [31:0]       mem_do;

  modport slave (
    input  im_req, im_addr,
    output im_grant, im_rvalid, im_rdata,
    input  dm_req, dm_web, dm_addr, dm_bweb, dm_wdata,
    output dm_grant, dm_rvalid, dm_rdata,
    output mem_ceb, mem_web, mem_a, mem_bweb, mem_di,
    input  mem_do
  );

  modport master (
    output im_req, im_addr,
    input  im_grant, im_rvalid, im_rdata,
    output dm_req, dm_web, dm_addr, dm_bweb, dm_wdata,
    input  dm_grant, dm_rvalid, dm_rdata,
    input  mem_ceb, mem_web, mem_a, mem_bweb, mem_di,
    output mem_do
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port SRAM between an instruction-fetch
// port (IM) and a data port (DM). One command per cycle, grants are
// combinational, read data returns with a 1-cycle latency and is steered
// back to the requester recorded in a registered owner tag.
//
// Build option: define MEM_ARB_RR_EN to replace "DM priority with IM
// starvation guard" by plain round-robin on simultaneous requests.
module mem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4    // legal range 1..15
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IM   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  owner_e      owner_q, owner_d;
  logic [31:0] im_rdata_q, im_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        im_win, dm_win;

`ifdef MEM_ARB_RR_EN
  logic last_im_q, last_im_d;   // 1 = IM was granted most recently
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt, starve_d;
`endif

  // Pick at most one winner from the current requests; nothing wins in reset.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    im_win = 1'b0;
    dm_win = 1'b0;
    if (!rst) begin
      if (bus.im_req && bus.dm_req) begin
`ifdef MEM_ARB_RR_EN
        im_win = !last_im_q;
`else
        im_win = (starve_cnt == STARVE_LIM);
`endif
        dm_win = !im_win;
      end else begin
        im_win = bus.im_req;
        dm_win = bus.dm_req;
      end
    end
  end

  // Drive the SRAM command from the winner, idle values otherwise.
  always_comb begin
    bus.mem_ceb  = 1'b1;
    bus.mem_web  = 1'b1;
    bus.mem_a    = '0;
    bus.mem_bweb = '1;
    bus.mem_di   = '0;
    if (im_win) begin
      bus.mem_ceb = 1'b0;
      bus.mem_a   = bus.im_addr;
    end else if (dm_win) begin
      bus.mem_ceb  = 1'b0;
      bus.mem_web  = bus.dm_web;
      bus.mem_a    = bus.dm_addr;
      bus.mem_bweb = bus.dm_bweb;
      bus.mem_di   = bus.dm_wdata;
    end
  end

  // Next-state: owner of the next return, held read data, fairness state.
  always_comb begin
    owner_d = OWN_NONE;
    if (im_win) begin
      owner_d = OWN_IM;
    end else if (dm_win && bus.dm_web) begin
      owner_d = OWN_DM;
    end

    im_rdata_d = (owner_q == OWN_IM) ? bus.mem_do : im_rdata_q;
    dm_rdata_d = (owner_q == OWN_DM) ? bus.mem_do : dm_rdata_q;

`ifdef MEM_ARB_RR_EN
    last_im_d = last_im_q;
    if (im_win) begin
      last_im_d = 1'b1;
    end else if (dm_win) begin
      last_im_d = 1'b0;
    end
`else
    starve_d = 4'd0;
    if (bus.im_req && !im_win) begin
      starve_d = (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
    end
`endif
  end

  // State registers with synchronous reset; an outstanding return is dropped.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      im_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_im_q  <= 1'b0;
`else
      starve_cnt <= 4'd0;
`endif
    end else begin
      owner_q    <= owner_d;
      im_rdata_q <= im_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_im_q  <= last_im_d;
`else
      starve_cnt <= starve_d;
`endif
    end
  end

  // Requester-facing outputs; return data passes straight from mem_do.
  assign bus.im_grant  = im_win;
  assign bus.dm_grant  = dm_win;
  assign bus.im_rvalid = !rst && (owner_q == OWN_IM);
  assign bus.dm_rvalid = !rst && (owner_q == OWN_DM);
  assign bus.im_rdata  = rst ? 32'd0 : im_rdata_d;
  assign bus.dm_rdata  = rst ? 32'd0 : dm_rdata_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized requesters against a behavioural model
// that is compared with the DUT on every falling clock edge.
module tb_mem_arbiter;
  localparam int ADDR_W     = 14;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) ifc ();

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_starve  = 0;   // consecutive cycles IM asked and lost
  bit          m_last_im = 1'b0;
  int          m_pend    = 0;   // 0 none, 1 IM read returning, 2 DM read returning
  logic [31:0] m_im_hold = '0;
  logic [31:0] m_dm_hold = '0;

  logic              e_im, e_dm, e_ceb, e_web, e_imv, e_dmv;
  logic [ADDR_W-1:0] e_a;
  logic [31:0]       e_bweb, e_di, e_imd, e_dmd;

  always @(negedge clk) begin
    e_im = 1'b0;
    e_dm = 1'b0;
    if (!rst) begin
      if (ifc.im_req && ifc.dm_req) begin
`ifdef MEM_ARB_RR_EN
        e_im = !m_last_im;
`else
        e_im = (m_starve >= STARVE_MAX);
`endif
        e_dm = !e_im;
      end else begin
        e_im = ifc.im_req;
        e_dm = ifc.dm_req;
      end
    end
    e_ceb  = !(e_im || e_dm);
    e_web  = e_dm ? ifc.dm_web : 1'b1;
    e_a    = e_im ? ifc.im_addr : (e_dm ? ifc.dm_addr : '0);
    e_bweb = e_dm ? ifc.dm_bweb : 32'hFFFF_FFFF;
    e_di   = e_dm ? ifc.dm_wdata : 32'd0;
    e_imv  = !rst && (m_pend == 1);
    e_dmv  = !rst && (m_pend == 2);
    e_imd  = rst ? 32'd0 : (e_imv ? ifc.mem_do : m_im_hold);
    e_dmd  = rst ? 32'd0 : (e_dmv ? ifc.mem_do : m_dm_hold);

    check("im_grant",  64'(ifc.im_grant),  64'(e_im));
    check("dm_grant",  64'(ifc.dm_grant),  64'(e_dm));
    check("both_grant", 64'(ifc.im_grant & ifc.dm_grant), 64'd0);
    check("mem_ceb",   64'(ifc.mem_ceb),   64'(e_ceb));
    check("mem_web",   64'(ifc.mem_web),   64'(e_web));
    check("mem_a",     64'(ifc.mem_a),     64'(e_a));
    check("mem_bweb",  64'(ifc.mem_bweb),  64'(e_bweb));
    check("mem_di",    64'(ifc.mem_di),    64'(e_di));
    check("im_rvalid", 64'(ifc.im_rvalid), 64'(e_imv));
    check("dm_rvalid", 64'(ifc.dm_rvalid), 64'(e_dmv));
    check("im_rdata",  64'(ifc.im_rdata),  64'(e_imd));
    check("dm_rdata",  64'(ifc.dm_rdata),  64'(e_dmd));

    // advance the model across the coming rising edge
    if (rst) begin
      m_starve  = 0;
      m_last_im = 1'b0;
      m_pend    = 0;
      m_im_hold = '0;
      m_dm_hold = '0;
    end else begin
      if (m_pend == 1) m_im_hold = ifc.mem_do;
      if (m_pend == 2) m_dm_hold = ifc.mem_do;
      m_pend = e_im ? 1 : ((e_dm && ifc.dm_web) ? 2 : 0);
      if (e_im) m_last_im = 1'b1;
      else if (e_dm) m_last_im = 1'b0;
      if (ifc.im_req && !e_im) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else m_starve = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    ifc.im_req   = 1'b0;
    ifc.im_addr  = '0;
    ifc.dm_req   = 1'b0;
    ifc.dm_web   = 1'b1;
    ifc.dm_addr  = '0;
    ifc.dm_bweb  = '1;
    ifc.dm_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  logic g_im, g_dm;
  int   dm_before_im;
  bit   seen_im;

  initial begin
    idle();
    ifc.mem_do = 32'h1357_9BDF;
    next_cyc();
    next_cyc();

    // reset values while rst is held
    mid();
    check("rst_im_grant",  64'(ifc.im_grant),  64'd0);
    check("rst_mem_ceb",   64'(ifc.mem_ceb),   64'd1);
    check("rst_mem_bweb",  64'(ifc.mem_bweb),  64'hFFFF_FFFF);
    check("rst_im_rdata",  64'(ifc.im_rdata),  64'd0);
    next_cyc();

    // back-to-back fetches, 1-cycle read latency, hold after last return
    do_reset();
    ifc.im_req  = 1'b1;
    ifc.im_addr = 14'h010;
    mid();
    check("f1_grant",  64'(ifc.im_grant),  64'd1);
    check("f1_addr",   64'(ifc.mem_a),     64'h010);
    check("f1_rvalid", 64'(ifc.im_rvalid), 64'd0);
    next_cyc();
    ifc.mem_do = 32'hA;
    mid();
    check("f2_grant",  64'(ifc.im_grant),  64'd1);
    check("f2_rvalid", 64'(ifc.im_rvalid), 64'd1);
    check("f2_rdata",  64'(ifc.im_rdata),  64'hA);
    next_cyc();
    ifc.mem_do = 32'hB;
    mid();
    check("f3_grant",  64'(ifc.im_grant),  64'd1);
    check("f3_rdata",  64'(ifc.im_rdata),  64'hB);
    next_cyc();
    ifc.im_req = 1'b0;
    ifc.mem_do = 32'hC;
    mid();
    check("f4_grant",  64'(ifc.im_grant),  64'd0);
    check("f4_rvalid", 64'(ifc.im_rvalid), 64'd1);
    check("f4_rdata",  64'(ifc.im_rdata),  64'hC);
    next_cyc();
    ifc.mem_do = 32'h55;
    mid();
    check("f5_rvalid", 64'(ifc.im_rvalid), 64'd0);
    check("f5_hold",   64'(ifc.im_rdata),  64'hC);
    next_cyc();

    // DM masked write: command same cycle, no return afterwards
    ifc.dm_req   = 1'b1;
    ifc.dm_web   = 1'b0;
    ifc.dm_addr  = 14'h020;
    ifc.dm_wdata = 32'hDEAD_BEEF;
    ifc.dm_bweb  = 32'h0000_FFFF;
    mid();
    check("w_grant", 64'(ifc.dm_grant), 64'd1);
    check("w_ceb",   64'(ifc.mem_ceb),  64'd0);
    check("w_web",   64'(ifc.mem_web),  64'd0);
    check("w_bweb",  64'(ifc.mem_bweb), 64'h0000_FFFF);
    check("w_di",    64'(ifc.mem_di),   64'hDEAD_BEEF);
    next_cyc();
    idle();
    ifc.mem_do = 32'h1234;
    mid();
    check("w_no_rvalid", 64'(ifc.dm_rvalid), 64'd0);
    check("w_rdata0",    64'(ifc.dm_rdata),  64'd0);
    next_cyc();

    // both requesting for 6 cycles
    do_reset();
    ifc.im_req  = 1'b1;
    ifc.im_addr = 14'h100;
    ifc.dm_req  = 1'b1;
    ifc.dm_addr = 14'h200;
    for (int i = 0; i < 6; i++) begin
      mid();
`ifdef MEM_ARB_RR_EN
      check($sformatf("tie_im_c%0d", i + 1), 64'(ifc.im_grant), 64'((i % 2) == 0));
      check($sformatf("tie_dm_c%0d", i + 1), 64'(ifc.dm_grant), 64'((i % 2) != 0));
`else
      check($sformatf("tie_im_c%0d", i + 1), 64'(ifc.im_grant), 64'(i == STARVE_MAX));
      check($sformatf("tie_dm_c%0d", i + 1), 64'(ifc.dm_grant), 64'(i != STARVE_MAX));
`endif
      next_cyc();
    end
    idle();

    // reset with a DM read outstanding drops the return
    do_reset();
    ifc.dm_req  = 1'b1;
    ifc.dm_addr = 14'h033;
    mid();
    check("rr_dm_grant", 64'(ifc.dm_grant), 64'd1);
    next_cyc();
    rst = 1'b1;
    idle();
    ifc.mem_do = 32'hFFFF_FFFF;
    mid();
    check("rr_rvalid_in_rst", 64'(ifc.dm_rvalid), 64'd0);
    check("rr_rdata_in_rst",  64'(ifc.dm_rdata),  64'd0);
    check("rr_ceb_in_rst",    64'(ifc.mem_ceb),   64'd1);
    next_cyc();
    rst = 1'b0;
    mid();
    check("rr_rvalid_after", 64'(ifc.dm_rvalid), 64'd0);
    check("rr_im_rv_after",  64'(ifc.im_rvalid), 64'd0);
    next_cyc();

`ifndef MEM_ARB_RR_EN
    // IM asks twice during DM traffic, withdraws, then starvation restarts from 0
    do_reset();
    ifc.dm_req  = 1'b1;
    ifc.dm_addr = 14'h040;
    ifc.im_req  = 1'b1;
    ifc.im_addr = 14'h050;
    for (int i = 0; i < 2; i++) begin
      mid();
      check("cancel_no_grant", 64'(ifc.im_grant), 64'd0);
      next_cyc();
    end
    ifc.im_req = 1'b0;
    mid();
    check("cancel_dropped", 64'(ifc.im_grant), 64'd0);
    next_cyc();
    mid();
    check("cancel_no_rvalid", 64'(ifc.im_rvalid), 64'd0);
    next_cyc();
    ifc.im_req   = 1'b1;
    dm_before_im = 0;
    seen_im      = 1'b0;
    for (int i = 0; i < 10 && !seen_im; i++) begin
      mid();
      if (ifc.im_grant) seen_im = 1'b1;
      else if (ifc.dm_grant) dm_before_im++;
      next_cyc();
    end
    check("starve_restart", 64'(dm_before_im), 64'(STARVE_MAX));
    idle();
`endif

    // randomized requesters that hold until granted or occasionally cancel
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      mid();
      g_im = ifc.im_grant;
      g_dm = ifc.dm_grant;
      next_cyc();
      ifc.mem_do = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      if (!ifc.im_req || g_im) begin
        ifc.im_req  = ($urandom_range(0, 3) != 0);
        ifc.im_addr = ADDR_W'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        ifc.im_req = 1'b0;
      end
      if (!ifc.dm_req || g_dm) begin
        ifc.dm_req   = ($urandom_range(0, 2) != 0);
        ifc.dm_web   = $urandom_range(0, 1) != 0;
        ifc.dm_addr  = ADDR_W'($urandom);
        ifc.dm_bweb  = $urandom;
        ifc.dm_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        ifc.dm_req = 1'b0;
      end
    end
    rst = 1'b0;
    idle();
    next_cyc();
    next_cyc();
    mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
